// File: rtl/teclado_pkg.sv
// Shared types and helpers for the parametrised matrix keypad scanner.
package teclado_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } t_scan_state;

    // Linear key code of a matrix position: row-major, row*COLS + col.
    function automatic int unsigned key_code_f(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned n_cols);
        return row * n_cols + col;
    endfunction

    // Larger of two integers, used to size shared counters.
    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/teclado_matricial_param_fifo.sv
// Small register-based FIFO holding debounced key codes.
// The head is always visible on head_o; a pop consumes it, a push appends.
// When full, a push is accepted only if a pop happens in the same cycle.
module key_fifo
    import teclado_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic full_d;
    logic empty_d;
    logic do_push_d;
    logic do_pop_d;

    // Occupancy flags and the accepted push/pop of this cycle.
    always_comb begin
        full_d    = (count_q == CNT_W'(DEPTH));
        empty_d   = (count_q == '0);
        do_pop_d  = pop_i && !empty_d;
        do_push_d = push_i && (!full_d || do_pop_d);
    end

    // Storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_d) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_d) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_d) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_d, do_pop_d})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_d;
    assign empty_o = empty_d;

endmodule

// File: rtl/teclado_matricial_param.sv
// Parametrised ROWS x COLS keypad scanner: walks an active-low row strobe,
// samples synchronised active-low columns, debounces press and release of a
// single key and queues its code in a small FIFO with a valid/ready head.
module teclado_matricial_param
    import teclado_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10,
    parameter int DEPTH        = 4,
    localparam int KEY_W       = $clog2(ROWS * COLS),
    localparam int ROW_W       = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COLS-1:0]  cols,
    output logic [ROWS-1:0]  rows,
    output logic [ROW_W-1:0] current_row,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             key_release,
    output logic             overflow
);

    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(max_f(SCAN_DIV, DEBOUNCE_CNT) + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]  ROWS_INIT  = {{(ROWS - 1){1'b1}}, 1'b0};

    // Column synchroniser.
    logic [COLS-1:0]  cols_meta_q;
    logic [COLS-1:0]  scols_q;

    // Scanner state.
    t_scan_state      state_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] db_q;
    logic [ROW_W-1:0] row_q;
    logic [ROWS-1:0]  rows_q;
    logic [KEY_W-1:0] cand_q;
    logic             held_q;
    logic             release_q;
    logic             push_q;
    logic             overflow_q;

    // Combinational helpers.
    logic             any_low_d;
    logic [COL_W-1:0] low_col_d;
    logic [KEY_W-1:0] code_d;
    logic [ROW_W-1:0] next_row_d;
    logic [ROWS-1:0]  next_rows_d;

    // FIFO interface.
    logic [KEY_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_d;

    // Bring the asynchronous column pins into the clk domain; idle-high reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cols_meta_q <= '1;
            scols_q     <= '1;
        end else begin
            cols_meta_q <= cols;
            scols_q     <= cols_meta_q;
        end
    end

    // Priority decode: lowest-index low column wins (scan downwards, last hit sticks).
    always_comb begin
        any_low_d = 1'b0;
        low_col_d = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!scols_q[c]) begin
                any_low_d = 1'b1;
                low_col_d = COL_W'(c);
            end
        end
        code_d = KEY_W'(key_code_f(32'(row_q), 32'(low_col_d), COLS));
    end

    // Next row index and matching one-cold strobe pattern.
    always_comb begin
        next_row_d  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        next_rows_d = {rows_q[ROWS-2:0], rows_q[ROWS-1]};
    end

    // Scanner FSM: row dwell, press debounce, hold, release debounce.
    // The push is a registered pulse, so the code lands in the FIFO on the
    // edge after key_held rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SCAN;
            dwell_q   <= '0;
            db_q      <= '0;
            row_q     <= '0;
            rows_q    <= ROWS_INIT;
            cand_q    <= '0;
            held_q    <= 1'b0;
            release_q <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            release_q <= 1'b0;
            push_q    <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (any_low_d) begin
                            cand_q  <= code_d;
                            db_q    <= '0;
                            state_q <= DEBOUNCE;
                        end else begin
                            row_q  <= next_row_d;
                            rows_q <= next_rows_d;
                        end
                    end else begin
                        dwell_q <= dwell_q + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (any_low_d && (code_d == cand_q)) begin
                        if (db_q == DB_LAST) begin
                            state_q <= PRESSED;
                            held_q  <= 1'b1;
                            push_q  <= 1'b1;
                            db_q    <= '0;
                        end else begin
                            db_q <= db_q + CNT_W'(1);
                        end
                    end else begin
                        state_q <= SCAN;
                        dwell_q <= '0;
                        db_q    <= '0;
                        row_q   <= next_row_d;
                        rows_q  <= next_rows_d;
                    end
                end
                PRESSED: begin
                    if (!any_low_d) begin
                        state_q <= RELEASE_DB;
                        db_q    <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (any_low_d) begin
                        // Release bounce: back to holding, no new push.
                        state_q <= PRESSED;
                        db_q    <= '0;
                    end else if (db_q == DB_LAST) begin
                        state_q   <= SCAN;
                        held_q    <= 1'b0;
                        release_q <= 1'b1;
                        db_q      <= '0;
                        dwell_q   <= '0;
                        row_q     <= next_row_d;
                        rows_q    <= next_rows_d;
                    end else begin
                        db_q <= db_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign pop_d = !fifo_empty && key_ready;

    // Sticky flag: a push arrived while full and nothing was popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !pop_d) begin
            overflow_q <= 1'b1;
        end
    end

    key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (DEPTH)
    ) u_key_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_q),
        .data_i  (cand_q),
        .pop_i   (pop_d),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rows        = rows_q;
    assign current_row = row_q;
    assign key_code    = fifo_head;
    assign key_valid   = !fifo_empty;
    assign key_held    = held_q;
    assign key_release = release_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_teclado_matricial_param.sv
// Directed bench for the keypad scanner; a small keypad model pulls a column
// low only while the row of a pressed key is strobed.
module tb_teclado_matricial_param;

    localparam int ROWS         = 4;
    localparam int COLS         = 4;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int DEPTH        = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [COLS-1:0] cols;
    logic [ROWS-1:0] rows;
    logic [1:0]      current_row;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_ready = 1'b0;
    logic            key_held;
    logic            key_release;
    logic            overflow;

    logic [ROWS-1:0][COLS-1:0] keymat = '0;

    int n_vec   = 0;
    int n_miss  = 0;
    int rel_cnt = 0;
    int rel0;
    bit ok;

    typedef struct {
        int              row;
        logic [COLS-1:0] mask;
        int              exp_code;
    } vec_t;

    vec_t vecs [7];
    int   exp_q [4];

    teclado_matricial_param #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cols        (cols),
        .rows        (rows),
        .current_row (current_row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .key_release (key_release),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its column to its row when strobed.
    always_comb begin
        cols = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!rows[r]) begin
                cols = cols & ~keymat[r];
            end
        end
    end

    // Count release pulses.
    always @(posedge clk) begin
        if (key_release) begin
            rel_cnt <= rel_cnt + 1;
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic lvl, input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick(1);
            if (key_held == lvl) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " rows"}, int'(rows), 14);
        check({tag, " current_row"}, int'(current_row), 0);
        check({tag, " key_code"}, int'(key_code), 0);
        check({tag, " key_valid"}, int'(key_valid), 0);
        check({tag, " key_held"}, int'(key_held), 0);
        check({tag, " key_release"}, int'(key_release), 0);
        check({tag, " overflow"}, int'(overflow), 0);
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    task automatic press_release(input string tag, input int r, input logic [COLS-1:0] m);
        bit f;
        keymat[r] = m;
        wait_held(1'b1, 200, f);
        check({tag, " press seen"}, int'(f), 1);
        tick(2);
        keymat[r] = '0;
        wait_held(1'b0, 100, f);
        check({tag, " release seen"}, int'(f), 1);
        tick(2);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        keymat    = '0;
        key_ready = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2, 4'b0010, 9};
        vecs[1] = '{0, 4'b1010, 1};
        vecs[2] = '{3, 4'b1000, 15};
        vecs[3] = '{1, 4'b0001, 4};
        vecs[4] = '{0, 4'b0001, 0};
        vecs[5] = '{3, 4'b0110, 13};
        vecs[6] = '{1, 4'b1100, 6};

        // Reset and idle scanning.
        tick(20);
        check_reset_vals("reset");
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            logic [3:0] exp_rows;
            tick(1);
            exp_rows = 4'b1111 ^ (4'b0001 << ((n / 4) % 4));
            check("scan rows", int'(rows), int'(exp_rows));
            check("scan current_row", int'(current_row), (n / 4) % 4);
        end
        check("scan key_valid", int'(key_valid), 0);
        $display("scan: idle rotation checked");

        // Press with 1-cycle glitches, then settle on key (2,1).
        for (int i = 0; i < 6; i++) begin
            keymat[2] = 4'b0010;
            tick(1);
            keymat[2] = 4'b0000;
            tick(1);
        end
        keymat[2] = 4'b0010;
        wait_held(1'b1, 200, ok);
        check("glitch press held", int'(ok), 1);
        tick(3);
        check("glitch key_valid", int'(key_valid), 1);
        check("glitch key_code", int'(key_code), 9);
        check("glitch key_held", int'(key_held), 1);
        $display("glitch press: code %0d", key_code);

        // Release with bounce.
        rel0 = rel_cnt;
        for (int i = 0; i < 6; i++) begin
            keymat[2] = 4'b0000;
            tick(1);
            keymat[2] = 4'b0010;
            tick(1);
        end
        tick(2);
        check("bounce still held", int'(key_held), 1);
        keymat = '0;
        wait_held(1'b0, 100, ok);
        check("bounce release seen", int'(ok), 1);
        tick(2);
        check("bounce release pulses", rel_cnt - rel0, 1);
        check("bounce key_valid", int'(key_valid), 1);
        check("bounce key_code", int'(key_code), 9);
        pop_one();
        check("bounce single entry", int'(key_valid), 0);
        $display("release bounce: %0d pulse(s)", rel_cnt - rel0);

        // 2-cycle low glitches never reach acceptance.
        for (int i = 0; i < 40; i++) begin
            keymat[1] = 4'b1000;
            tick(2);
            keymat[1] = 4'b0000;
            tick(1);
        end
        tick(5);
        check("short glitch key_valid", int'(key_valid), 0);
        check("short glitch key_held", int'(key_held), 0);
        $display("short glitches: key_valid %0d", key_valid);

        // Table of single presses.
        for (int v = 0; v < 7; v++) begin
            rel0 = rel_cnt;
            press_release("table", vecs[v].row, vecs[v].mask);
            check("table key_valid", int'(key_valid), 1);
            check("table key_code", int'(key_code), vecs[v].exp_code);
            check("table release pulses", rel_cnt - rel0, 1);
            $display("vec %0d: row %0d mask %b -> code %0d", v, vecs[v].row, vecs[v].mask, key_code);
            pop_one();
            check("table drained", int'(key_valid), 0);
        end

        // Overflow: five presses with no consumer.
        key_ready = 1'b0;
        press_release("ovf0", 0, 4'b0100);
        press_release("ovf1", 1, 4'b1000);
        press_release("ovf2", 2, 4'b0001);
        press_release("ovf3", 3, 4'b0100);
        check("ovf full no overflow", int'(overflow), 0);
        press_release("ovf4", 3, 4'b0010);
        check("ovf key_valid", int'(key_valid), 1);
        check("ovf overflow", int'(overflow), 1);
        exp_q = '{2, 7, 8, 14};
        for (int i = 0; i < 4; i++) begin
            check("ovf pop valid", int'(key_valid), 1);
            check("ovf pop code", int'(key_code), exp_q[i]);
            $display("ovf pop %0d: code %0d", i, key_code);
            pop_one();
        end
        check("ovf drained", int'(key_valid), 0);
        check("ovf sticky", int'(overflow), 1);

        // Full FIFO, push and pop in the same cycle.
        do_reset();
        check("fullpp overflow cleared", int'(overflow), 0);
        press_release("fill0", 0, 4'b1000);
        press_release("fill1", 1, 4'b0010);
        press_release("fill2", 2, 4'b0100);
        press_release("fill3", 3, 4'b0001);
        keymat[2] = 4'b1000;
        wait_held(1'b1, 200, ok);
        check("fullpp press seen", int'(ok), 1);
        check("fullpp head", int'(key_code), 3);
        pop_one();
        check("fullpp no overflow", int'(overflow), 0);
        keymat = '0;
        wait_held(1'b0, 100, ok);
        check("fullpp release seen", int'(ok), 1);
        tick(2);
        check("fullpp still no overflow", int'(overflow), 0);
        exp_q = '{5, 10, 12, 11};
        for (int i = 0; i < 4; i++) begin
            check("fullpp pop valid", int'(key_valid), 1);
            check("fullpp pop code", int'(key_code), exp_q[i]);
            $display("fullpp pop %0d: code %0d", i, key_code);
            pop_one();
        end
        check("fullpp drained", int'(key_valid), 0);

        // Reset asserted mid-cycle while a key is held.
        keymat[1] = 4'b0100;
        wait_held(1'b1, 200, ok);
        check("rstp press seen", int'(ok), 1);
        tick(3);
        check("rstp key_valid before", int'(key_valid), 1);
        check("rstp key_code before", int'(key_code), 6);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rstp");
        keymat = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rstp restart rows", int'(rows), 14);
        check("rstp restart row", int'(current_row), 0);
        tick(3);
        check("rstp advance row", int'(current_row), 1);
        check("rstp fifo empty", int'(key_valid), 0);
        $display("reset during press: restart row %0d", current_row);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
